// File: rtl/pfb_pkg.sv
// Shared definitions for the PFB tap accumulator slice.
// Holds default product/sample widths, coefficient fraction bits, the
// default channel/tap geometry, and the typedefs for products, output
// samples and the accumulator word that the default geometry implies.
package pfb_pkg;

  localparam int PFB_PROD_W    = 31;
  localparam int PFB_SAMP_W    = 16;
  localparam int PFB_COEF_FRAC = 15;
  localparam int PFB_NCHAN     = 4;
  localparam int PFB_NTAPS     = 8;
  localparam int PFB_ACC_W     = PFB_PROD_W + $clog2(PFB_NTAPS);

  typedef logic signed [PFB_PROD_W-1:0] prod_t;
  typedef logic signed [PFB_SAMP_W-1:0] samp_t;
  typedef logic signed [PFB_ACC_W-1:0]  acc_t;

endpackage

// File: rtl/pfb_round_sat.sv
// Combinational round-and-reduce unit: sum -> OUT_W-bit sample.
// Rounds half toward +inf: (sum + 2^(SHIFT-1)) >>> SHIFT, then reduces to
// OUT_W bits. Build option PFB_ACC_SATURATE_EN selects clamping to the
// signed OUT_W range; without it the result wraps (low OUT_W bits kept).
// Ports:
//   i_sum  : signed accumulated sum, ACC_W bits
//   o_data : signed output sample, OUT_W bits
module pfb_round_sat
  import pfb_pkg::*;
#(
  parameter int ACC_W = PFB_ACC_W,
  parameter int OUT_W = PFB_SAMP_W,
  parameter int SHIFT = PFB_COEF_FRAC
)(
  input  logic signed [ACC_W-1:0] i_sum,
  output logic signed [OUT_W-1:0] o_data
);

  // One guard bit so adding the rounding constant can never overflow.
  logic signed [ACC_W:0] w_half;
  logic signed [ACC_W:0] w_rnd;
  logic signed [ACC_W:0] w_shr;

  assign w_half = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  assign w_rnd  = {i_sum[ACC_W-1], i_sum} + w_half;
  assign w_shr  = w_rnd >>> SHIFT;

`ifdef PFB_ACC_SATURATE_EN
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    o_data = w_shr[OUT_W-1:0];
    if (w_shr > MAXV)      o_data = MAXV[OUT_W-1:0];
    else if (w_shr < MINV) o_data = MINV[OUT_W-1:0];
  end
`else
  // Upper bits are deliberately dropped: two's-complement wrap.
  logic w_unused;
  assign w_unused = ^w_shr[ACC_W:OUT_W];
  assign o_data   = w_shr[OUT_W-1:0];
`endif

endmodule

// File: rtl/pfb_multichannel_tap_accumulator.sv
// PFB tap accumulator: sums NTAPS signed products per channel for NCHAN
// tap-major/channel-minor interleaved channels, rounds/scales each sum to
// OUT_WIDTH and emits one sample per channel per frame.
// Build option PFB_ACC_SATURATE_EN (in pfb_round_sat): clamp vs wrap.
// Ports:
//   ap_clk, ap_rst          : clock, synchronous active-high reset
//   s_data/s_last/s_valid   : product stream in, s_ready back-pressure out
//   m_data/m_chan/m_valid   : filtered sample out, m_ready from downstream
//   err                     : sticky frame-alignment error
module pfb_multichannel_tap_accumulator
  import pfb_pkg::*;
#(
  parameter int NCHAN     = PFB_NCHAN,
  parameter int NTAPS     = PFB_NTAPS,
  parameter int IN_WIDTH  = PFB_PROD_W,
  parameter int OUT_WIDTH = PFB_SAMP_W,
  parameter int SHIFT     = PFB_COEF_FRAC
)(
  input  logic                                         ap_clk,
  input  logic                                         ap_rst,
  input  logic signed [IN_WIDTH-1:0]                   s_data,
  input  logic                                         s_last,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  output logic signed [OUT_WIDTH-1:0]                  m_data,
  output logic [((NCHAN > 1) ? $clog2(NCHAN) : 1)-1:0] m_chan,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic                                         err
);

  localparam int ACC_WIDTH = IN_WIDTH + $clog2(NTAPS);
  localparam int CHW       = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int TAPW      = $clog2(NTAPS);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(NCHAN - 1);
  localparam logic [TAPW-1:0] TAP_LAST = TAPW'(NTAPS - 1);

  logic [CHW-1:0]                r_chan_cnt;
  logic [TAPW-1:0]               r_tap_cnt;
  logic                          r_err;
  logic signed [ACC_WIDTH-1:0]   r_acc [NCHAN];
  logic signed [OUT_WIDTH-1:0]   r_m_data;
  logic [CHW-1:0]                r_m_chan;
  logic                          r_m_valid;

  logic                          w_accept;
  logic                          w_chan_wrap;
  logic                          w_tap_last;
  logic                          w_misalign;
  logic signed [ACC_WIDTH-1:0]   w_sext;
  logic signed [ACC_WIDTH-1:0]   w_sum;
  logic signed [OUT_WIDTH-1:0]   w_result;

  // Uniform stall: every tap waits when the single output slot is full,
  // so the read-modify-write order never has to be tracked.
  assign s_ready     = !r_m_valid || m_ready;
  assign w_accept    = s_valid && s_ready;
  assign w_chan_wrap = (r_chan_cnt == CH_LAST);
  assign w_tap_last  = (r_tap_cnt == TAP_LAST);
  assign w_misalign  = (s_last != (w_chan_wrap && w_tap_last));
  assign w_sext      = ACC_WIDTH'(s_data);

  // Tap 0 overwrites, so stale contents after reset or a bad frame are
  // never folded in. With NCHAN=1 the async read of the same entry being
  // written this edge is still the pre-edge value, so no hazard.
  assign w_sum = (r_tap_cnt == '0) ? w_sext : r_acc[r_chan_cnt] + w_sext;

  pfb_round_sat #(
    .ACC_W (ACC_WIDTH),
    .OUT_W (OUT_WIDTH),
    .SHIFT (SHIFT)
  ) u_round (
    .i_sum  (w_sum),
    .o_data (w_result)
  );

  // Position counters and frame check. A misaligned beat is still
  // processed normally; only the position is forced back to (t0,c0).
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_chan_cnt <= '0;
      r_tap_cnt  <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      if (w_misalign) begin
        r_err      <= 1'b1;
        r_chan_cnt <= '0;
        r_tap_cnt  <= '0;
      end else if (w_chan_wrap) begin
        r_chan_cnt <= '0;
        r_tap_cnt  <= w_tap_last ? '0 : r_tap_cnt + TAPW'(1);
      end else begin
        r_chan_cnt <= r_chan_cnt + CHW'(1);
      end
    end
  end

  // Accumulator storage is intentionally not reset.
  always_ff @(posedge ap_clk) begin
    if (w_accept) r_acc[r_chan_cnt] <= w_sum;
  end

  // Single-entry output register; a load wins over a drain on the same edge.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_chan  <= '0;
    end else if (w_accept && w_tap_last) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_result;
      r_m_chan  <= r_chan_cnt;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_chan  = r_m_chan;
  assign err     = r_err;

endmodule

// File: tb/tb_pfb_multichannel_tap_accumulator.sv
module tb_pfb_multichannel_tap_accumulator;
  import pfb_pkg::*;

  localparam int NC = 4;
  localparam int NT = 8;
  localparam int NB = NC * NT;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b0;
  logic signed [30:0] s_data = '0;
  logic               s_last = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic signed [15:0] m_data;
  logic [1:0]         m_chan;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic               err;

  int checks = 0;
  int errors = 0;
  int prod[NB];
  logic [15:0] exp_d[$];
  int          exp_c[$];

  always #5 ap_clk = ~ap_clk;

  pfb_multichannel_tap_accumulator dut (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_chan  (m_chan),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .err     (err)
  );

  // Reference: per-channel sum of the frame's taps, rounded half up,
  // then clamped or wrapped to 16 bits.
  function automatic logic [15:0] ref_out(input longint s);
    longint r;
    r = (s + 64'sd16384) >>> 15;
`ifdef PFB_ACC_SATURATE_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  function automatic logic [15:0] chan_ref(input int c);
    longint s = 0;
    for (int t = 0; t < NT; t++) s += longint'(prod[t*NC + c]);
    return ref_out(s);
  endfunction

  task automatic fill_const(input int v);
    for (int i = 0; i < NB; i++) prod[i] = v;
  endtask

  task automatic fill_rand();
    logic [30:0] u;
    for (int i = 0; i < NB; i++) begin
      u = 31'($urandom);
      prod[i] = int'($signed(u));
    end
  endtask

  task automatic drive(input int d, input bit last);
    int n = 0;
    s_data  = d[30:0];
    s_last  = last;
    s_valid = 1'b1;
    @(negedge ap_clk);
    while (!s_ready && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (!s_ready) begin
      errors++;
      $display("FAIL drive_timeout s_ready=%0b required 1", s_ready);
    end
    @(posedge ap_clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Sends the first nbeats beats of prod[] with s_last on beat last_at and
  // queues the outputs the final-tap beats should generate.
  task automatic send_frame(input int nbeats, input int last_at, input bit chk_lat);
    for (int c = 0; c < NC; c++)
      if ((NT-1)*NC + c < nbeats) begin
        exp_d.push_back(chan_ref(c));
        exp_c.push_back(c);
      end
    for (int i = 0; i < nbeats; i++) begin
      drive(prod[i], i == last_at);
      if (chk_lat && i >= (NT-1)*NC) begin
        checks++;
        if (m_valid !== 1'b1 || m_chan !== 2'(i - (NT-1)*NC) || m_data !== chan_ref(i - (NT-1)*NC)) begin
          errors++;
          $display("FAIL latency beat=%0d got v=%0b ch=%0d d=%0h required v=1 ch=%0d d=%0h",
                   i, m_valid, m_chan, m_data, i - (NT-1)*NC, chan_ref(i - (NT-1)*NC));
        end
      end
    end
  endtask

  task automatic settle(input string name);
    repeat (4) @(posedge ap_clk);
    #1;
    checks++;
    if (exp_d.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required 0", name, exp_d.size());
      exp_d.delete();
      exp_c.delete();
    end
  endtask

  task automatic check_err(input string name, input logic req);
    checks++;
    if (err !== req) begin
      errors++;
      $display("FAIL %s_err got %0b required %0b", name, err, req);
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 16'h0 || m_chan !== 2'd0 || err !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset got v=%0b d=%0h ch=%0d err=%0b rdy=%0b required 0 0 0 0 1",
               m_valid, m_data, m_chan, err, s_ready);
    end
  endtask

  task automatic test_const();
    m_ready = 1'b1;
    fill_const(32768);
    send_frame(NB, NB-1, 1);
    fill_const(-32768);
    send_frame(NB, NB-1, 1);
    settle("const");
    check_err("const", 1'b0);
  endtask

  task automatic test_rounding();
    fill_const(0);
    prod[0] = 16384;   // c0 -> 1
    prod[1] = 16383;   // c1 -> 0
    prod[2] = -16384;  // c2 -> 0
    prod[3] = -16385;  // c3 -> -1
    send_frame(NB, NB-1, 1);
    fill_const(1073741823);
    send_frame(NB, NB-1, 1);
    fill_const(-1073741824);
    send_frame(NB, NB-1, 1);
    settle("boundary");
  endtask

  task automatic test_backpressure();
    logic [15:0] hd;
    logic [1:0]  hc;
    int n;
    fill_rand();
    m_ready = 1'b0;
    fork
      send_frame(NB, NB-1, 0);
      begin
        n = 0;
        while (!m_valid && n < 400) begin
          @(negedge ap_clk);
          n++;
        end
        checks++;
        if (m_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_first_out m_valid=%0b required 1", m_valid);
        end
        hd = m_data;
        hc = m_chan;
        repeat (20) begin
          @(negedge ap_clk);
          checks++;
          if (s_ready !== 1'b0 || m_data !== hd || m_chan !== hc || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got rdy=%0b v=%0b d=%0h ch=%0d required 0 1 %0h %0d",
                     s_ready, m_valid, m_data, m_chan, hd, hc);
          end
        end
        @(posedge ap_clk);
        #1;
        m_ready = 1'b1;
      end
    join
    settle("bp");
  endtask

  task automatic test_random();
    bit done = 1'b0;
    fork
      begin
        repeat (4) begin
          fill_rand();
          send_frame(NB, NB-1, 0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge ap_clk);
          #1;
          m_ready = ($urandom_range(0, 2) != 0);
        end
        m_ready = 1'b1;
      end
    join
    settle("random");
    check_err("random", 1'b0);
  endtask

  task automatic test_misalign();
    m_ready = 1'b1;
    fill_rand();
    send_frame(NB-1, (NT-1)*NC + 2, 1);   // s_last early at (t7,c2)
    check_err("misalign", 1'b1);
    fill_rand();
    send_frame(NB, NB-1, 1);
    settle("misalign");
    check_err("misalign_sticky", 1'b1);
  endtask

  task automatic test_mid_reset();
    fill_const(32768);
    for (int i = 0; i <= 3*NC + 1; i++) drive(prod[i], 1'b0);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midreset got v=%0b err=%0b required 0 0", m_valid, err);
    end
    send_frame(NB, NB-1, 1);
    settle("midreset");
    check_err("midreset", 1'b0);
  endtask

  initial begin
    logic [15:0] d;
    int          c;
    fork
      forever begin
        @(negedge ap_clk);
        if (!ap_rst && m_valid && m_ready) begin
          checks++;
          if (exp_d.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected d=%0h ch=%0d required none", m_data, m_chan);
          end else begin
            d = exp_d.pop_front();
            c = exp_c.pop_front();
            if (m_data !== d || m_chan !== 2'(c)) begin
              errors++;
              $display("FAIL out_data got d=%0h ch=%0d required d=%0h ch=%0d", m_data, m_chan, d, c);
            end
          end
        end
      end
    join_none

    test_reset();
    test_const();
    test_rounding();
    test_backpressure();
    test_random();
    test_misalign();
    test_mid_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
